vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Shares the single-port video RAM between two requesters: CPU `VGA` instruction writes and the display scan-out reader. CPU writes are buffered in a small FIFO, and the CPU is stalled only when that FIFO is full. Display reads normally win the port. A starvation guard forces a pending write through after a bounded wait. The block sits between the MiniAlu execute stage, the VGA timing/scan-out logic and the video RAM.

## Interface
- `FIFO_DEPTH`, default 4: CPU write buffer entries; must be a power of 2, minimum 2.
- `STARVE_LIMIT`, default 8: consecutive blocked cycles before a write is forced; range 1..255.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `iWrReq` in 1: CPU issues a `VGA` pixel write this cycle.
- `iWrRow` in 8: pixel row.
- `iWrCol` in 8: pixel column.
- `iWrColor` in 3: pixel color (`COLOR_*` encoding).
- `oWrStall` out 1: FIFO full. The CPU must hold the instruction and `iWrReq` high until this drops.
- `iRdReq` in 1: display requests one pixel this cycle.
- `iRdAddr` in 16: {row, col} of the requested pixel.
- `oRdData` out 3: color returned for the read granted last cycle.
- `oRdValid` out 1: `oRdData` is valid this cycle.
- `oRdMiss` out 1: a read requested last cycle was dropped because a write was forced.
- `oMemAddr` out 16: video RAM address.
- `oMemWe` out 1: video RAM write enable.
- `oMemWData` out 3: video RAM write data.
- `iMemRData` in 3: video RAM synchronous read data (1-cycle latency).

## Operation
- **FIFO push:** entry {row, col, color} is pushed when `iWrReq & ~full`. A request while full is ignored; the CPU re-presents it.
- **Count update:** push and pop may happen in the same cycle; count is unchanged. Pop only when non-empty.
- **Full flag:** `oWrStall = full`. It is derived from the registered count, so a same-cycle pop does not admit a push when full.
- **Port decision each cycle** (combinational from current state and `iRdReq`):
  - **FORCE_WR:** FIFO non-empty and `starve_cnt == STARVE_LIMIT`. Pop head; `oMemWe=1`, `oMemAddr={row,col}`, `oMemWData=color`. A concurrent `iRdReq` is dropped.
  - **GRANT_RD:** `iRdReq=1`, and FORCE_WR does not apply. `oMemWe=0`, `oMemAddr=iRdAddr`.
  - **GRANT_WR:** no read, FIFO non-empty. Pop head and write as in FORCE_WR.
  - **IDLE:** `oMemWe=0`, `oMemAddr=0`, `oMemWData=0`.
- **Starvation counter** `starve_cnt` (8-bit):
  - Increments in GRANT_RD while the FIFO is non-empty.
  - Clears in GRANT_WR, in FORCE_WR, and whenever the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **Read return:** `oRdValid` is the registered GRANT_RD flag. `oRdData = iMemRData` when `oRdValid=1`, else 0.
- **Read miss:** `oRdMiss` is the registered flag for "FORCE_WR with `iRdReq=1`". `oRdValid` and `oRdMiss` are never both 1.
- **Ordering:**
  - Writes reach memory in FIFO order.
  - A read of an address still queued returns the old memory contents; no forwarding.
  - A write and a read of the same address in consecutive cycles follow RAM semantics: the write completes first.
- **Reset:** clears the FIFO (pending writes are discarded, including reset mid-burst), `starve_cnt=0`, and all registered flags.

## Timing
- **Reset values:**
  - `oWrStall=0`, `oRdValid=0`, `oRdMiss=0`, `oRdData=0`.
  - `oMemWe=0`, `oMemAddr=0`, `oMemWData=0` (the FIFO is empty after reset, so the port is IDLE).
- **Write latency:**
  - Push at the edge ending cycle N; head is visible in N+1.
  - With no read, `oMemWe=1` in N+1.
  - Worst case with continuous reads: N+1+`STARVE_LIMIT` for the head entry.
- **Read latency:** `iRdReq` in cycle N produces `oRdValid`/`oRdData` in N+1, unless N was FORCE_WR, in which case `oRdMiss=1` in N+1.
- **Stall timing:**
  - `oWrStall` rises the cycle after the push that fills the FIFO.
  - It falls the cycle after the first pop from full.
- **Throughput:** one memory operation per cycle. Back-to-back pushes are sustained at 1/cycle while the port is otherwise idle.

## Test plan
- **Write, no reads:** after reset, push (row 3, col 5, RED); no reads. Expect `oMemWe=1`, `oMemAddr=16'h0305`, `oMemWData=RED` exactly one cycle after the push. The FIFO is then empty and the port IDLE.
- **Fill with reads held:** hold `iRdReq=1` continuously; push 5 writes on consecutive cycles (`FIFO_DEPTH=4`). Expect `oWrStall=1` after the 4th push and the 5th request ignored. Expect the first forced write on the 8th consecutive GRANT_RD cycle plus 1 (`STARVE_LIMIT=8`), with `oRdMiss=1` the cycle after it.
- **Read return:** preload address 16'h0A0B with GREEN; issue a read with the FIFO empty. Expect `oRdValid=1`, `oRdData=GREEN` next cycle, and `oRdMiss=0`.
- **Simultaneous push and pop:** with the FIFO holding 2 entries and no reads, push each cycle. Count stays 2, writes emerge in order, and `oWrStall` stays 0.
- **Reset mid-burst:** with 3 queued writes and a read in flight, assert `Reset` for 1 cycle. The next cycle shows `oMemWe=0`, `oRdValid=0`, `oWrStall=0`, and no queued write ever reaches memory.
- **Counter clear:** interleave reads with one idle cycle every 4. Expect `starve_cnt` clears on each GRANT_WR and `oRdMiss` is never asserted.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares the single-port video RAM between buffered CPU
// pixel writes and the display scan-out reader. Reads normally win; a
// starvation counter forces the head write through after STARVE_LIMIT
// consecutive blocked cycles.
module vga_vram_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iWrReq,
    input  logic [7:0]  iWrRow,
    input  logic [7:0]  iWrCol,
    input  logic [2:0]  iWrColor,
    output logic        oWrStall,
    input  logic        iRdReq,
    input  logic [15:0] iRdAddr,
    output logic [2:0]  oRdData,
    output logic        oRdValid,
    output logic        oRdMiss,
    output logic [15:0] oMemAddr,
    output logic        oMemWe,
    output logic [2:0]  oMemWData,
    input  logic [2:0]  iMemRData
);

    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);
    localparam logic [PW:0] FULL  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_GRANT_RD,
        OP_GRANT_WR,
        OP_FORCE_WR
    } port_op_e;

    // Entry layout: {row, col, color}
    logic [18:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [7:0]    r_starve;
    logic          r_rd_valid;
    logic          r_rd_miss;

    port_op_e      w_op;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [18:0]   w_head;

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_push  = iWrReq & ~w_full;
    assign w_pop   = (w_op == OP_FORCE_WR) | (w_op == OP_GRANT_WR);

    // Port decision. Held IDLE during reset so a queued write being
    // discarded cannot slip into memory on the reset cycle itself.
    always_comb begin
        w_op = OP_IDLE;
        if (!Reset) begin
            if (!w_empty && r_starve == LIMIT) w_op = OP_FORCE_WR;
            else if (iRdReq)                   w_op = OP_GRANT_RD;
            else if (!w_empty)                 w_op = OP_GRANT_WR;
        end
    end

    // Memory port drive from the decision
    always_comb begin
        oMemWe    = 1'b0;
        oMemAddr  = '0;
        oMemWData = '0;
        case (w_op)
            OP_FORCE_WR, OP_GRANT_WR: begin
                oMemWe    = 1'b1;
                oMemAddr  = w_head[18:3];
                oMemWData = w_head[2:0];
            end
            OP_GRANT_RD: oMemAddr = iRdAddr;
            default: ;
        endcase
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge Clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= {iWrRow, iWrCol, iWrColor};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // Starvation counter: counts reads that block a pending write
    always_ff @(posedge Clock) begin
        if (Reset || w_empty || w_pop)
            r_starve <= '0;
        else if (w_op == OP_GRANT_RD && r_starve != LIMIT)
            r_starve <= r_starve + 8'd1;
    end

    // Registered read-return and read-miss flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
        end else begin
            r_rd_valid <= (w_op == OP_GRANT_RD);
            r_rd_miss  <= (w_op == OP_FORCE_WR) & iRdReq;
        end
    end

    assign oWrStall = w_full;
    assign oRdValid = r_rd_valid;
    assign oRdMiss  = r_rd_miss;
    assign oRdData  = r_rd_valid ? iMemRData : 3'd0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: directed scenarios followed by a random
// phase, all checked against a queue-based reference model and a
// reference copy of video memory.
module tb_vga_vram_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;

    logic        Clock, Reset;
    logic        iWrReq, iRdReq;
    logic [7:0]  iWrRow, iWrCol;
    logic [2:0]  iWrColor, iMemRData, oRdData, oMemWData;
    logic [15:0] iRdAddr, oMemAddr;
    logic        oWrStall, oRdValid, oRdMiss, oMemWe;

    vga_vram_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .iWrReq(iWrReq), .iWrRow(iWrRow), .iWrCol(iWrCol), .iWrColor(iWrColor),
        .oWrStall(oWrStall),
        .iRdReq(iRdReq), .iRdAddr(iRdAddr),
        .oRdData(oRdData), .oRdValid(oRdValid), .oRdMiss(oRdMiss),
        .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemWData(oMemWData),
        .iMemRData(iMemRData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Video RAM attached to the DUT: synchronous, 1-cycle read latency
    logic [2:0] ram [65536];
    always @(posedge Clock) begin
        if (oMemWe) ram[oMemAddr] <= oMemWData;
        iMemRData <= ram[oMemAddr];
    end

    // Reference model state
    typedef struct { logic [15:0] addr; logic [2:0] color; } wr_t;
    wr_t        q[$];
    logic [2:0] mm [65536];
    int         m_wait;
    logic       p_valid, p_miss;
    logic [2:0] p_data;
    logic       m_force, m_rd, m_we;
    logic       c_rst, c_wr, c_rd;
    logic [15:0] c_waddr, c_raddr;
    logic [2:0] c_color;

    int ncmp, nfail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge and let combinational outputs settle
    task automatic drv(input logic rst, input logic wr, input logic [7:0] row,
                       input logic [7:0] col, input logic [2:0] color,
                       input logic rd, input logic [15:0] ra);
        Reset = rst; iWrReq = wr; iWrRow = row; iWrCol = col; iWrColor = color;
        iRdReq = rd; iRdAddr = ra;
        c_rst = rst; c_wr = wr; c_waddr = {row, col}; c_color = color;
        c_rd = rd; c_raddr = ra;
        #1;
    endtask

    // Compare all outputs with what the arbitration rules predict
    task automatic cmp();
        int n;
        n = q.size();
        m_force = !c_rst && n > 0 && m_wait == LIMIT;
        m_rd    = !c_rst && c_rd && !m_force;
        m_we    = m_force || (!c_rst && !c_rd && n > 0);
        chk("mem_we", oMemWe, m_we);
        chk("mem_addr", oMemAddr, m_we ? q[0].addr : (m_rd ? c_raddr : 16'h0));
        chk("mem_wdata", oMemWData, m_we ? q[0].color : 3'd0);
        chk("wr_stall", oWrStall, n == DEPTH);
        chk("rd_valid", oRdValid, p_valid);
        chk("rd_data", oRdData, p_valid ? p_data : 3'd0);
        chk("rd_miss", oRdMiss, p_miss);
    endtask

    // Advance the model by one cycle and move to the next falling edge
    task automatic adv();
        int n;
        n = q.size();
        if (c_rst) begin
            q.delete();
            m_wait = 0; p_valid = 0; p_miss = 0; p_data = 0;
        end else begin
            p_valid = m_rd;
            p_data  = mm[c_raddr];
            p_miss  = m_force && c_rd;
            if (m_we) begin
                mm[q[0].addr] = q[0].color;
                void'(q.pop_front());
            end
            if (n == 0 || m_we) m_wait = 0;
            else if (m_rd && m_wait < LIMIT) m_wait++;
            if (c_wr && n < DEPTH) q.push_back('{c_waddr, c_color});
        end
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic step(input logic rst, input logic wr, input logic [7:0] row,
                        input logic [7:0] col, input logic [2:0] color,
                        input logic rd, input logic [15:0] ra);
        drv(rst, wr, row, col, color, rd, ra);
        cmp();
        adv();
    endtask

    initial begin
        ncmp = 0; nfail = 0;
        m_wait = 0; p_valid = 0; p_miss = 0; p_data = 0;
        for (int i = 0; i < 65536; i++) begin ram[i] = 3'd0; mm[i] = 3'd0; end
        Reset = 1'b1; iWrReq = 0; iWrRow = 0; iWrCol = 0; iWrColor = 0;
        iRdReq = 0; iRdAddr = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);

        // Reset values with idle inputs
        drv(0, 0, 0, 0, 0, 0, 0);
        cmp();
        chk("rst_stall", oWrStall, 0); chk("rst_valid", oRdValid, 0);
        chk("rst_miss", oRdMiss, 0);   chk("rst_data", oRdData, 0);
        chk("rst_we", oMemWe, 0);      chk("rst_addr", oMemAddr, 0);
        chk("rst_wdata", oMemWData, 0);
        adv();

        // Single write, no reads: appears one cycle after the push
        step(0, 1, 8'd3, 8'd5, RED, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0); cmp();
        chk("w1_we", oMemWe, 1); chk("w1_addr", oMemAddr, 16'h0305);
        chk("w1_wdata", oMemWData, RED);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0); cmp();
        chk("w1_idle_we", oMemWe, 0); chk("w1_idle_addr", oMemAddr, 0);
        adv();

        // Read return: preload 0A0B with GREEN then read it back
        step(0, 1, 8'h0A, 8'h0B, GREEN, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0A0B);
        drv(0, 0, 0, 0, 0, 0, 0); cmp();
        chk("rd_ret_valid", oRdValid, 1); chk("rd_ret_data", oRdData, GREEN);
        chk("rd_ret_miss", oRdMiss, 0);
        adv();

        // Fill with reads held: stall after 4th push, force on cycle 9
        for (int i = 0; i < 12; i++) begin
            drv(0, i < 5, 8'(16 + i), 8'(i), BLUE, 1, 16'(i * 7));
            cmp();
            if (i == 4)  chk("fill_stall", oWrStall, 1);
            if (i == 8)  chk("fill_not_forced", oMemWe, 0);
            if (i == 9)  chk("fill_forced", oMemWe, 1);
            if (i == 9)  chk("fill_force_addr", oMemAddr, 16'h1000);
            if (i == 10) chk("fill_miss", oRdMiss, 1);
            if (i == 10) chk("fill_miss_novalid", oRdValid, 0);
            adv();
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Simultaneous push and pop with two entries queued
        step(0, 1, 8'h20, 8'h00, RED, 1, 16'h0001);
        step(0, 1, 8'h20, 8'h01, GREEN, 1, 16'h0002);
        for (int i = 0; i < 6; i++) begin
            drv(0, 1, 8'h21, 8'(i), 3'(i + 1), 0, 0);
            cmp();
            chk("pp_stall", oWrStall, 0);
            chk("pp_we", oMemWe, 1);
            adv();
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-burst with a read in flight
        step(0, 1, 8'h30, 8'h01, RED, 1, 16'h0A0B);
        step(0, 1, 8'h30, 8'h02, RED, 1, 16'h0A0B);
        step(0, 1, 8'h30, 8'h03, RED, 1, 16'h0A0B);
        step(0, 0, 0, 0, 0, 1, 16'h0A0B);
        drv(1, 0, 0, 0, 0, 0, 0); cmp();
        chk("rstb_we", oMemWe, 0);
        adv();
        drv(0, 0, 0, 0, 0, 0, 0); cmp();
        chk("rstb_we2", oMemWe, 0); chk("rstb_valid", oRdValid, 0);
        chk("rstb_stall", oWrStall, 0);
        adv();
        for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 0, 1, {8'h30, 8'(i)});
        drv(0, 0, 0, 0, 0, 0, 0); cmp();
        chk("rstb_discard", oRdData, 3'd0);
        adv();

        // Counter clear: idle every 4th cycle, never forced
        for (int i = 0; i < 40; i++) begin
            drv(0, (i % 4) == 0, 8'h40, 8'(i), 3'(i), (i % 4) != 3, 16'(i));
            cmp();
            chk("clr_miss", oRdMiss, 0);
            adv();
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small address set to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 3'($urandom),
                 ($urandom_range(0, 9) < 7),
                 {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
